// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and UART-side signal bundle for the shared transmitter arbiter.
// The master modport is the arbiter's view; the slave modport is the view of
// whatever surrounds it (producers plus the UART core).
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data_i;
    logic [NREQ-1:0]   valid_i;
    logic [NREQ-1:0]   last_i;
    logic [NREQ-1:0]   ready_o;
    logic [NREQ-1:0]   gnt_o;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              tx_busy;

    modport master (
        input  req, data_i, valid_i, last_i, tx_busy,
        output ready_o, gnt_o, tx_data, tx_wr
    );

    modport slave (
        output req, data_i, valid_i, last_i, tx_busy,
        input  ready_o, gnt_o, tx_data, tx_wr
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter between
// NREQ byte-stream producers. An owner keeps the transmitter until it sends a
// byte marked last, drops its request, or idles in GRANT for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus,
    output logic              busy_o,
    output logic              timeout_o
);
    localparam int IDXW = $clog2(NREQ);
    localparam logic [15:0]     WDOG_MAX   = 16'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] LAST_RESET = IDXW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] last_owner_q, last_owner_d;
    logic [15:0]     wdog_q, wdog_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_wr_q, tx_wr_d;
    logic            last_q, last_d;
    logic            drain_first_q, drain_first_d;
    logic            timeout_q, timeout_d;

    logic [IDXW-1:0] winner;
    logic            winner_found;
    logic [NREQ-1:0] gnt_dec;
    logic [NREQ-1:0] ready_dec;

    // Position 'step' places above 'base', wrapping modulo NREQ.
    function automatic logic [IDXW-1:0] rr_index(input logic [IDXW-1:0] base,
                                                 input int step);
        int c;
        c = int'(base) + step;
        if (c >= NREQ) c = c - NREQ;
        return IDXW'(c);
    endfunction

    // Round-robin search: first requester above the previous owner, wrapping,
    // so the previous owner itself is considered last.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!winner_found && bus.req[rr_index(last_owner_q, i)]) begin
                winner       = rr_index(last_owner_q, i);
                winner_found = 1'b1;
            end
        end
    end

    // Next-state logic: packet ownership, byte hand-off, tx_busy pacing and
    // the GRANT watchdog.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        wdog_d        = wdog_q;
        tx_data_d     = tx_data_q;
        tx_wr_d       = 1'b0;
        last_d        = last_q;
        drain_first_d = drain_first_q;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    owner_d = winner;
                    wdog_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.valid_i[owner_q]) begin
                    tx_data_d = bus.data_i[{owner_q, 3'b000} +: 8];
                    last_d    = bus.last_i[owner_q];
                    tx_wr_d   = 1'b1;
                    state_d   = SEND;
                end else if (!bus.req[owner_q]) begin
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else if (wdog_q == WDOG_MAX) begin
                    timeout_d    = 1'b1;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            SEND: begin
                drain_first_d = 1'b1;
                state_d       = DRAIN;
            end
            DRAIN: begin
                if (drain_first_q) begin
                    drain_first_d = 1'b0;
                end else if (!bus.tx_busy) begin
                    if (last_q) begin
                        last_owner_d = owner_q;
                        state_d      = IDLE;
                    end else begin
                        wdog_d  = '0;
                        state_d = GRANT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            last_owner_q  <= LAST_RESET;
            wdog_q        <= '0;
            tx_data_q     <= '0;
            tx_wr_q       <= 1'b0;
            last_q        <= 1'b0;
            drain_first_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            wdog_q        <= wdog_d;
            tx_data_q     <= tx_data_d;
            tx_wr_q       <= tx_wr_d;
            last_q        <= last_d;
            drain_first_q <= drain_first_d;
            timeout_q     <= timeout_d;
        end
    end

    // Grant and ready decode from registered state and owner only.
    always_comb begin
        gnt_dec   = '0;
        ready_dec = '0;
        if (state_q != IDLE) gnt_dec[owner_q] = 1'b1;
        if (state_q == GRANT) ready_dec[owner_q] = 1'b1;
    end

    assign bus.gnt_o   = gnt_dec;
    assign bus.ready_o = ready_dec;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_wr   = tx_wr_q;
    assign busy_o      = (state_q != IDLE);
    assign timeout_o   = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: a small producer model per
// requester plus a UART busy model, with hand-computed expected values.
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam logic [7:0] BASE [NREQ] = '{8'hA0, 8'h10, 8'h41, 8'h30};

    logic clk = 1'b0;
    logic rst_n;
    logic busy_o;
    logic timeout_o;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy_o   (busy_o),
        .timeout_o(timeout_o)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int              pkts_left [NREQ];
    int              len       [NREQ];
    int              idx       [NREQ];
    logic [NREQ-1:0] en;
    int              busy_len;
    int              busy_cnt;
    logic [7:0]      tx_q[$];
    int              tx_cyc_q[$];
    int              grant_q[$];
    logic [NREQ-1:0] prev_gnt;
    int              cycle;
    int              n_checks;
    int              n_pass;

    // Producers present byte BASE[k]+idx while enabled and hold req while
    // packets remain; the UART looks busy for busy_len cycles per write.
    always_comb begin
        bus.req     = '0;
        bus.valid_i = '0;
        bus.last_i  = '0;
        bus.data_i  = '0;
        for (int k = 0; k < NREQ; k++) begin
            bus.req[k]            = (pkts_left[k] > 0);
            bus.valid_i[k]        = en[k];
            bus.last_i[k]         = (idx[k] == len[k] - 1);
            bus.data_i[8*k +: 8]  = BASE[k] + 8'(idx[k]);
        end
        bus.tx_busy = (busy_cnt != 0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One clock: observe mid-cycle, then update the models just after the edge.
    task automatic tick();
        logic [NREQ-1:0] hs;
        logic            wr_seen;
        @(negedge clk);
        hs      = bus.valid_i & bus.ready_o;
        wr_seen = bus.tx_wr;
        if (bus.tx_wr) begin
            tx_q.push_back(bus.tx_data);
            tx_cyc_q.push_back(cycle);
        end
        if (bus.gnt_o != prev_gnt && bus.gnt_o != '0) begin
            for (int k = 0; k < NREQ; k++)
                if (bus.gnt_o[k]) grant_q.push_back(k);
        end
        prev_gnt = bus.gnt_o;
        @(posedge clk);
        #1;
        cycle++;
        if (wr_seen) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        for (int k = 0; k < NREQ; k++) begin
            if (hs[k]) begin
                if (idx[k] + 1 == len[k]) begin
                    idx[k] = 0;
                    if (pkts_left[k] > 0) pkts_left[k]--;
                end else begin
                    idx[k]++;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int npkts,
                                 input int nbytes, input logic [NREQ-1:0] en_mask);
        for (int k = 0; k < NREQ; k++) begin
            pkts_left[k] = mask[k] ? npkts : 0;
            len[k]       = nbytes;
            idx[k]       = 0;
        end
        en = en_mask;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus('0, 0, 1, '0);
        busy_len = 0;
        busy_cnt = 0;
        tx_q.delete();
        tx_cyc_q.delete();
        grant_q.delete();
        prev_gnt = '0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] txAt(input int i);
        return (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] grantAt(input int i);
        return (i < grant_q.size()) ? 32'(grant_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gapAt(input int i);
        return (i + 1 < tx_cyc_q.size()) ? 32'(tx_cyc_q[i+1] - tx_cyc_q[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic waitTx(input int n, input int budget);
        int c = 0;
        while (tx_q.size() < n && c < budget) begin tick(); c++; end
    endtask

    task automatic waitGrants(input int n, input int budget);
        int c = 0;
        while (grant_q.size() < n && c < budget) begin tick(); c++; end
    endtask

    task automatic waitIdle(input int budget);
        int c = 0;
        while (busy_o && c < budget) begin tick(); c++; end
    endtask

    task automatic waitReady(input int k, input int budget);
        int c = 0;
        while (!bus.ready_o[k] && c < budget) begin tick(); c++; end
    endtask

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: got hang, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Directed test sequence.
    initial begin
        logic early;
        int   c;
        n_checks = 0;
        n_pass   = 0;
        cycle    = 0;
        rst_n    = 1'b0;
        en       = '0;

        // Reset values.
        resetDut();
        checkOutput("rst_gnt",     bus.gnt_o,   4'b0000);
        checkOutput("rst_ready",   bus.ready_o, 4'b0000);
        checkOutput("rst_tx_wr",   bus.tx_wr,   1'b0);
        checkOutput("rst_tx_data", bus.tx_data, 8'h00);
        checkOutput("rst_busy",    busy_o,      1'b0);
        checkOutput("rst_timeout", timeout_o,   1'b0);

        // Single 3-byte packet from requester 2, UART busy 10 cycles per byte.
        applyStimulus(4'b0100, 1, 3, 4'b0100);
        busy_len = 10;
        tick();
        checkOutput("single_gnt",   bus.gnt_o,   4'b0100);
        checkOutput("single_ready", bus.ready_o, 4'b0100);
        checkOutput("single_busy",  busy_o,      1'b1);
        waitTx(3, 200);
        waitIdle(100);
        checkOutput("single_ntx",   tx_q.size(), 3);
        checkOutput("single_b0",    txAt(0), 8'h41);
        checkOutput("single_b1",    txAt(1), 8'h42);
        checkOutput("single_b2",    txAt(2), 8'h43);
        checkOutput("single_gap01", gapAt(0), 13);
        checkOutput("single_gap12", gapAt(1), 13);
        tick();
        checkOutput("single_end_gnt",  bus.gnt_o, 4'b0000);
        checkOutput("single_end_busy", busy_o,    1'b0);
        checkOutput("single_ngrant",   grant_q.size(), 1);

        // Fairness: everyone requesting one-byte packets continuously.
        resetDut();
        applyStimulus(4'b1111, 1000, 1, 4'b1111);
        waitGrants(6, 200);
        checkOutput("fair_ngrant", grant_q.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("fair_g%0d", i), grantAt(i), i % 4);
        checkOutput("fair_b0", txAt(0), 8'hA0);
        checkOutput("fair_b1", txAt(1), 8'h10);
        checkOutput("fair_b2", txAt(2), 8'h41);
        checkOutput("fair_b3", txAt(3), 8'h30);

        // Back-to-back 2-byte packets from requesters 1 and 3.
        resetDut();
        applyStimulus(4'b1010, 3, 2, 4'b1010);
        waitGrants(6, 200);
        checkOutput("b2b_ngrant", grant_q.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("b2b_g%0d", i), grantAt(i), (i % 2 == 0) ? 1 : 3);
        checkOutput("b2b_b0", txAt(0), 8'h10);
        checkOutput("b2b_b1", txAt(1), 8'h11);
        checkOutput("b2b_b2", txAt(2), 8'h30);
        checkOutput("b2b_b3", txAt(3), 8'h31);

        // Watchdog: requester 0 never sends, requester 1 waits behind it.
        resetDut();
        applyStimulus(4'b0011, 1, 1, 4'b0010);
        tick();
        checkOutput("wdog_gnt0", bus.gnt_o, 4'b0001);
        early = 1'b0;
        repeat (15) begin
            tick();
            if (timeout_o || bus.gnt_o != 4'b0001) early = 1'b1;
        end
        checkOutput("wdog_no_early", early, 1'b0);
        tick();
        checkOutput("wdog_pulse",     timeout_o, 1'b1);
        checkOutput("wdog_rel_gnt",   bus.gnt_o, 4'b0000);
        tick();
        checkOutput("wdog_pulse_end", timeout_o, 1'b0);
        checkOutput("wdog_next_gnt",  bus.gnt_o, 4'b0010);

        // Abort: requester 2 drops req in GRANT after one of three bytes.
        resetDut();
        applyStimulus(4'b0100, 1, 3, 4'b0100);
        waitTx(1, 50);
        en = '0;
        waitReady(2, 50);
        checkOutput("abort_in_grant", bus.ready_o, 4'b0100);
        pkts_left[2] = 0;
        tick();
        checkOutput("abort_gnt",  bus.gnt_o, 4'b0000);
        checkOutput("abort_busy", busy_o,    1'b0);
        repeat (5) tick();
        checkOutput("abort_ntx", tx_q.size(), 1);

        // Valid and req drop in the same GRANT cycle: byte still goes out.
        applyStimulus(4'b0100, 1, 3, 4'b0000);
        waitReady(2, 20);
        checkOutput("drop_in_grant", bus.ready_o, 4'b0100);
        en[2]        = 1'b1;
        pkts_left[2] = 0;
        tick();
        en = '0;
        repeat (10) tick();
        checkOutput("drop_ntx",  tx_q.size(), 2);
        checkOutput("drop_byte", txAt(1), 8'h41);
        checkOutput("drop_gnt",  bus.gnt_o, 4'b0000);
        checkOutput("drop_busy", busy_o,    1'b0);

        // Reset asserted mid-packet, during SEND.
        resetDut();
        applyStimulus(4'b0100, 1, 3, 4'b0100);
        c = 0;
        while (!bus.tx_wr && c < 50) begin tick(); c++; end
        checkOutput("mid_reach_send", bus.tx_wr, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_gnt",     bus.gnt_o,   4'b0000);
        checkOutput("mid_ready",   bus.ready_o, 4'b0000);
        checkOutput("mid_tx_wr",   bus.tx_wr,   1'b0);
        checkOutput("mid_tx_data", bus.tx_data, 8'h00);
        checkOutput("mid_busy",    busy_o,      1'b0);
        checkOutput("mid_timeout", timeout_o,   1'b0);
        resetDut();
        applyStimulus(4'b1111, 1, 1, 4'b1111);
        tick();
        checkOutput("mid_first_gnt", bus.gnt_o, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter of the sensor-node SoC between up to NREQ byte-stream producers (CPU console, sensor sampler, GPIO event reporter, …). Grants are packet-level: once granted, a requester owns the transmitter until it sends a byte marked last, drops its request, or stalls past a watchdog. The block sits between the producers and the UART core's write/busy interface.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 1024: idle cycles in GRANT before forced release, 2..65535.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester transmit request; held for the whole packet.
- data_i  in  8*NREQ  byte from requester k on bits [8k+7:8k].
- valid_i  in  NREQ  byte valid, per requester.
- last_i  in  NREQ  byte is the final byte of the packet, qualified by valid_i.
- ready_o  out  NREQ  byte accepted when valid_i[k] && ready_o[k].
- gnt_o  out  NREQ  one-hot owner indication; all zero when idle.
- tx_data  out  8  byte to the UART core.
- tx_wr  out  1  one-cycle write strobe to the UART core.
- tx_busy  in  1  UART core busy, asserted no later than the cycle after tx_wr.
- busy_o  out  1  high whenever state is not IDLE.
- timeout_o  out  1  one-cycle pulse on watchdog release.

## Operation
- States: IDLE, GRANT, SEND, DRAIN.
- IDLE: if any req bit is high, the winner is the first set bit searching upward from (last_owner+1) mod NREQ with wrap. Register owner, go to GRANT. gnt_o becomes one-hot on the next cycle.
- GRANT: ready_o[owner]=1, all other ready_o=0.
  - On valid_i[owner]: latch the owner's byte into tx_data and the last_i[owner] flag into last_q, then go to SEND.
  - Else if req[owner]=0: abort and go to IDLE, with last_owner=owner.
  - Else increment the watchdog. When it reaches TIMEOUT-1, pulse timeout_o, go to IDLE, last_owner=owner.
  - Acceptance has priority over abort and watchdog in the same cycle.
- SEND: tx_wr=1 for exactly one cycle, then DRAIN.
- DRAIN: the first cycle is unconditional, covering tx_busy latency. After that, wait for tx_busy=0.
  - If last_q=1: go to IDLE, last_owner=owner.
  - Else: return to GRANT with the watchdog cleared.
- The watchdog clears on every entry to GRANT. It counts only in GRANT.
- ready_o, gnt_o and busy_o decode from registered state and owner only; they have no combinational path from inputs.
- Requests from non-owners are ignored until IDLE.
- A requester whose req is still high after its packet completes gets the lowest priority at the next arbitration.
- Reset values (asynchronous, rst=0): state IDLE, gnt_o=0, ready_o=0, tx_wr=0, tx_data=0, busy_o=0, timeout_o=0, watchdog=0, last_owner=NREQ-1, so requester 0 wins first after reset.
- A reset mid-packet drops the packet silently. tx_wr never glitches high during or after reset.

## Timing
- Arbitration: req seen at edge n in IDLE gives gnt_o and ready_o at n+1.
- Byte path: accept at edge m gives tx_wr=1 and tx_data valid during cycle m+1. DRAIN is entered at m+2.
- Minimum byte period = 4 cycles (GRANT, SEND, 2×DRAIN) when tx_busy is never asserted. Otherwise it is paced by tx_busy.
- Packet release to next grant: IDLE costs 1 cycle. From the last DRAIN exit, the next owner gets gnt_o 2 edges later.
- The watchdog fires on the TIMEOUT-th consecutive GRANT cycle without a byte accepted.

## Test plan
- Single packet: req[2]=1, bytes 0x41,0x42,0x43 (last on 0x43), tx_busy modelled as 10 cycles per byte.
  - gnt_o=0100 one cycle after req.
  - Three tx_wr pulses with tx_data 0x41,0x42,0x43, each more than 10 cycles apart.
  - Then gnt_o=0000, busy_o=0.
- Fairness: req=1111 held continuously, every requester sends one-byte packets. Grant order is 0,1,2,3,0,1.
- Back-to-back rotation: req[1] and req[3] both send 2-byte packets repeatedly. Grants alternate 1,3,1,3 with no starvation.
- Watchdog, TIMEOUT=16: requester 0 is granted, never asserts valid, and keeps req high.
  - timeout_o pulses exactly 16 GRANT cycles after grant.
  - gnt_o=0000 the following cycle; requester 1 (also requesting) is granted next.
- Abort: requester 2 drops req after 1 of 3 bytes, while in GRANT. The block returns to IDLE with no further tx_wr. Simultaneous valid and req drop: the byte is still sent.
- Reset mid-packet: assert rst=0 during SEND.
  - All outputs are 0 immediately, asynchronously.
  - After release with req=1111, requester 0 is granted first.
